mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, the number of BUSY cycles without m_valid before an access is aborted.
REQ-002 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 if_req  in  1  fetch stage requests an instruction read; held until if_ready.
REQ-005 if_addr  in  16  fetch address.
REQ-006 d_rd / d_wr  in  1 each  MEM stage read/write request; held until d_ready.
REQ-007 d_addr / d_wdata  in  16 each  data address and write data.
REQ-008 if_rdata / d_rdata  out  16 each  registered read data returned to each requester.
REQ-009 if_ready / d_ready  out  1 each  one-cycle completion pulse to each requester.
REQ-010 stall_if / stall_d  out  1 each  stall requests to the pipeline stages.
REQ-011 m_addr / m_wdata  out  16 each  shared memory port address and write data.
REQ-012 m_re / m_we  out  1 each  shared memory read and write strobes.
REQ-013 m_rdata  in  16  memory read data, valid when m_valid=1.
REQ-014 m_valid  in  1  memory completion, one cycle, only while m_re or m_we is high.
REQ-015 err  out  1  sticky timeout flag.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY_D, BUSY_I and DONE, with one transaction outstanding at most.
REQ-017 IDLE: if d_rd|d_wr, go to BUSY_D; otherwise, if if_req, go to BUSY_I; otherwise, stay in IDLE. Data SHALL always have priority (older instruction).
REQ-018 On entering BUSY_x, the block SHALL register m_addr, m_wdata and m_re/m_we from the granted requester; these SHALL be held constant until the state is left.
REQ-019 If d_rd and d_wr are both high, the access SHALL be a write (m_we=1, m_re=0).
REQ-020 In BUSY_x with m_valid=1, the block SHALL capture m_rdata into the granted rdata register (reads only), drop m_re/m_we at the next edge and go to DONE.
REQ-021 DONE SHALL last exactly one cycle, assert the granted ready pulse, ignore all requests and then return to IDLE; an access therefore costs memory latency plus 2 cycles.
REQ-022 A write SHALL leave d_rdata unchanged; the non-granted rdata register SHALL never change.
REQ-023 stall_d SHALL be combinational: (d_rd|d_wr) & ~d_ready.
REQ-024 stall_if SHALL be combinational: if_req & ~if_ready, OR'd with stall_d.
REQ-025 An 8-bit wait counter SHALL clear on entry to BUSY_x and increment each BUSY cycle without m_valid.
REQ-026 When the wait counter reaches TIMEOUT, the block SHALL abort to DONE, load 16'h0000 into the granted rdata (reads), set err and deassert the strobes.
REQ-027 m_valid SHALL be ignored in IDLE and DONE.
REQ-028 A request arriving in the same cycle as DONE SHALL be granted in the following IDLE cycle.

Reset
REQ-029 While rst=1 at posedge clk, the block SHALL set state=IDLE, m_re=m_we=0, m_addr=m_wdata=0, if_rdata=d_rdata=0, ready pulses=0, wait counter=0 and err=0.
REQ-030 Reset during BUSY_x SHALL abandon the access with no ready pulse; a late m_valid after reset SHALL be ignored.

Structure
REQ-031 The state enum typedef and the width constants (ADDR_W=16, DATA_W=16) SHALL live in a shared package, mem_arb_pkg.
REQ-032 The wait counter and its compare logic SHALL be one sub-module, mem_arb_watchdog (in: clk, rst, clr, en; out: expired).

Verification
REQ-033 Fetch only: if_req=1, if_addr=16'h0040, memory returns 16'hA5A5 after 3 cycles -> m_re held 3 cycles, if_rdata=16'hA5A5, if_ready pulses once, stall_if high until that pulse.
REQ-034 Simultaneous requests: if_req and d_rd both rise in the same cycle -> data access granted first; fetch is issued in the IDLE cycle after DONE; stall_if stays high throughout.
REQ-035 Write: d_wr=1, d_addr=16'h0100, d_wdata=16'h1234 -> m_we=1 with those values until m_valid; d_ready pulses; d_rdata is unchanged.
REQ-036 Timeout: TIMEOUT=4, m_valid never asserted -> abort after 4 BUSY cycles, rdata=0, ready pulses, err=1 and stays 1 until rst.
REQ-037 Reset mid-access: rst in the 2nd BUSY_I cycle -> next cycle IDLE, m_re=0, no if_ready; m_valid the cycle after has no effect.
REQ-038 Back-to-back: d_rd held through DONE with if_req low -> exactly one memory access per request; a new access starts only after the requester reasserts.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
package mem_arb_pkg;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_D,
    BUSY_I,
    DONE
  } arb_state_t;
endpackage

// File: rtl/mem_arb_watchdog.sv
// Wait-cycle counter for an outstanding memory access; flags the cycle whose
// increment would reach TIMEOUT.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WAIT_W-1:0] cnt;
  logic [WAIT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + WAIT_W'(1);
  assign expired = en && (cnt_inc == WAIT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and MEM stages onto one shared memory port, data first,
// with one transaction outstanding and a sticky timeout flag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] if_rdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              if_ready,
  output logic              d_ready,
  output logic              stall_if,
  output logic              stall_d,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_re,
  output logic              m_we,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_valid,
  output logic              err
);

  arb_state_t state;
  logic       busy;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_expired;

  assign busy   = (state == BUSY_D) || (state == BUSY_I);
  assign wd_clr = (state == IDLE) && (d_rd || d_wr || if_req);
  assign wd_en  = busy && !m_valid;

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  assign stall_d  = (d_rd | d_wr) & ~d_ready;
  assign stall_if = (if_req & ~if_ready) | stall_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      m_re     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      err      <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (d_rd || d_wr) begin
            state   <= BUSY_D;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_we    <= d_wr;
            m_re    <= ~d_wr;   // a simultaneous read+write is issued as a write
          end else if (if_req) begin
            state   <= BUSY_I;
            m_addr  <= if_addr;
            m_wdata <= '0;
            m_re    <= 1'b1;
            m_we    <= 1'b0;
          end
        end
        BUSY_D, BUSY_I: begin
          // Completion and abort share one exit; an abort returns zero read data.
          if (m_valid || wd_expired) begin
            state <= DONE;
            m_re  <= 1'b0;
            m_we  <= 1'b0;
            if (!m_valid) err <= 1'b1;
            if (state == BUSY_D) begin
              d_ready <= 1'b1;
              if (m_re) d_rdata <= m_valid ? m_rdata : '0;
            end else begin
              if_ready <= 1'b1;
              if (m_re) if_rdata <= m_valid ? m_rdata : '0;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single accesses plus
// hand-written multi-cycle sequences, with a completion scoreboard.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        d_rd = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] if_rdata, d_rdata;
  logic        if_ready, d_ready, stall_if, stall_d;
  logic [15:0] m_addr, m_wdata;
  logic        m_re, m_we;
  logic [15:0] m_rdata = 16'hDEAD;
  logic        m_valid = 1'b0;
  logic        err;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .if_rdata(if_rdata), .d_rdata(d_rdata),
    .if_ready(if_ready), .d_ready(d_ready),
    .stall_if(stall_if), .stall_d(stall_d),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_re(m_re), .m_we(m_we),
    .m_rdata(m_rdata), .m_valid(m_valid), .err(err)
  );

  typedef struct {
    bit          is_d;
    logic [15:0] val;
  } sb_t;

  typedef struct {
    int          kind;   // 0 fetch, 1 read, 2 write, 3 read+write
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mdata;
    int          lat;
    logic        exp_re;
    logic        exp_we;
    logic [15:0] exp_if;
    logic [15:0] exp_d;
  } vec_t;

  sb_t         sb[$];
  vec_t        vecs[6];
  int          errors = 0;
  int          checks = 0;
  bit          drop_d = 0;
  bit          drop_i = 0;
  bit          mem_en = 1;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [15:0] mem_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ready();
    sb_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ready: got if_ready=%b d_ready=%b expected no pulse", if_ready, d_ready);
    end else begin
      e = sb.pop_front();
      check("ready_src", {if_ready, d_ready}, e.is_d ? 2'b01 : 2'b10);
      check("ready_rdata", e.is_d ? d_rdata : if_rdata, e.val);
    end
  endtask

  // One clock: sample #1 after the edge, retire completions, let requesters
  // drop after their ready cycle, then advance the memory model.
  task automatic step();
    @(posedge clk);
    #1;
    if (drop_d) begin d_rd = 1'b0; d_wr = 1'b0; drop_d = 0; end
    if (drop_i) begin if_req = 1'b0; drop_i = 0; end
    if (d_ready) drop_d = 1;
    if (if_ready) drop_i = 1;
    if (if_ready || d_ready) check_ready();
    if (mem_en) begin
      if (m_re || m_we) begin
        mem_cnt++;
        m_valid = (mem_cnt == mem_lat);
        m_rdata = m_valid ? mem_data : 16'hDEAD;
      end else begin
        mem_cnt = 0;
        m_valid = 1'b0;
        m_rdata = 16'hDEAD;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n = 0;
    int strobes = 0;
    int hold_bad = 0;
    int stall_bad = 0;
    bit got = 0;
    mem_lat  = v.lat;
    mem_data = v.mdata;
    case (v.kind)
      0: begin if_req = 1'b1; if_addr = v.addr; end
      1: d_rd = 1'b1;
      2: d_wr = 1'b1;
      default: begin d_rd = 1'b1; d_wr = 1'b1; end
    endcase
    if (v.kind != 0) begin d_addr = v.addr; d_wdata = v.wdata; end
    sb.push_back('{v.kind != 0, (v.kind == 0) ? v.exp_if : v.exp_d});
    while (!got && n < 30) begin
      step();
      n++;
      if (if_ready || d_ready) got = 1;
      else begin
        if (m_re || m_we) begin
          strobes++;
          if (m_addr !== v.addr || m_re !== v.exp_re || m_we !== v.exp_we ||
              (v.exp_we && m_wdata !== v.wdata)) hold_bad++;
        end
        if (stall_if !== 1'b1 || stall_d !== (v.kind != 0)) stall_bad++;
      end
    end
    check("vec_done", got, 1);
    check("vec_latency", n, v.lat + 1);
    check("vec_strobes", strobes, v.lat);
    check("vec_hold", hold_bad, 0);
    check("vec_stall_wait", stall_bad, 0);
    check("vec_stall_done", {stall_if, stall_d}, 0);
    step();
    check("vec_pulse_once", {if_ready, d_ready, m_re, m_we}, 0);
    check("vec_if_rdata", if_rdata, v.exp_if);
    check("vec_d_rdata", d_rdata, v.exp_d);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, td, tf, acc, rdy, stall_bad, busy;
    bit got, seen_busy, cur, prev;
    logic [15:0] first_addr;

    vecs[0] = '{0, 16'h0040, 16'h0000, 16'hA5A5, 3, 1'b1, 1'b0, 16'hA5A5, 16'h0000};
    vecs[1] = '{1, 16'h0200, 16'h7777, 16'h5A5A, 1, 1'b1, 1'b0, 16'hA5A5, 16'h5A5A};
    vecs[2] = '{2, 16'h0100, 16'h1234, 16'hBEEF, 2, 1'b0, 1'b1, 16'hA5A5, 16'h5A5A};
    vecs[3] = '{3, 16'h0300, 16'hCAFE, 16'hFFFF, 2, 1'b0, 1'b1, 16'hA5A5, 16'h5A5A};
    vecs[4] = '{0, 16'h0042, 16'h0000, 16'h0F0F, 2, 1'b1, 1'b0, 16'h0F0F, 16'h5A5A};
    vecs[5] = '{1, 16'h0400, 16'h0000, 16'hC3C3, 3, 1'b1, 1'b0, 16'h0F0F, 16'hC3C3};

    // Reset state
    repeat (3) step();
    check("rst_strobes", {m_re, m_we, if_ready, d_ready}, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    check("rst_err", err, 0);
    check("rst_stall", {stall_if, stall_d}, 0);
    rst = 1'b0;
    step();
    check("idle_strobes", {m_re, m_we}, 0);

    foreach (vecs[i]) run_vec(vecs[i]);
    check("err_clear", err, 0);

    // Simultaneous fetch and data request: data first, fetch after DONE+IDLE
    mem_lat = 2; mem_data = 16'h1111;
    if_req = 1'b1; if_addr = 16'h0050; d_rd = 1'b1; d_addr = 16'h0500;
    sb.push_back('{1'b1, 16'h1111});
    sb.push_back('{1'b0, 16'h2222});
    n = 0; td = -1; tf = -1; got = 0; seen_busy = 0; stall_bad = 0; first_addr = 16'hFFFF;
    while (!got && n < 40) begin
      step();
      n++;
      if (!seen_busy && m_re) begin seen_busy = 1; first_addr = m_addr; end
      if (d_ready) begin td = n; mem_data = 16'h2222; end
      if (tf < 0 && m_re && m_addr == 16'h0050) tf = n;
      if (if_ready) got = 1;
      else if (stall_if !== 1'b1) stall_bad++;
    end
    check("simul_done", got, 1);
    check("simul_first_grant", first_addr, 16'h0500);
    check("simul_fetch_after_idle", tf, td + 2);
    check("simul_stall_if", stall_bad, 0);
    step();

    // Back-to-back: request held through DONE must not issue a second access
    mem_lat = 1; mem_data = 16'h3333;
    d_rd = 1'b1; d_addr = 16'h0700;
    sb.push_back('{1'b1, 16'h3333});
    acc = 0; rdy = 0; prev = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      cur = m_re | m_we;
      if (cur && !prev) acc++;
      prev = cur;
      if (d_ready) rdy++;
    end
    check("b2b_one_access", acc, 1);
    check("b2b_one_ready", rdy, 1);
    mem_data = 16'h4444;
    d_rd = 1'b1; d_addr = 16'h0702;
    sb.push_back('{1'b1, 16'h4444});
    for (int i = 0; i < 6; i++) begin
      step();
      cur = m_re | m_we;
      if (cur && !prev) acc++;
      prev = cur;
      if (d_ready) rdy++;
    end
    check("b2b_second_access", acc, 2);
    check("b2b_second_ready", rdy, 2);
    check("b2b_d_rdata", d_rdata, 16'h4444);

    // Timeout: memory never answers
    mem_en = 0; m_valid = 1'b0;
    d_rd = 1'b1; d_addr = 16'h0600;
    sb.push_back('{1'b1, 16'h0000});
    n = 0; got = 0; busy = 0;
    while (!got && n < 30) begin
      step();
      n++;
      if (d_ready) got = 1;
      else if (m_re) busy++;
    end
    check("to_done", got, 1);
    check("to_busy_cycles", busy, TO);
    check("to_err", err, 1);
    check("to_strobes", {m_re, m_we}, 0);
    repeat (3) step();
    check("to_err_sticky", err, 1);
    mem_en = 1; mem_lat = 1; mem_data = 16'h5555;
    if_req = 1'b1; if_addr = 16'h0070;
    sb.push_back('{1'b0, 16'h5555});
    repeat (5) step();
    check("to_err_after_ok", err, 1);
    check("to_if_rdata", if_rdata, 16'h5555);

    // Reset in the second BUSY_I cycle, then a late m_valid
    mem_en = 0; m_valid = 1'b0;
    if_req = 1'b1; if_addr = 16'h0060;
    step();
    check("rmid_b1_re", m_re, 1);
    step();
    rst = 1'b1; if_req = 1'b0;
    step();
    check("rmid_strobes", {m_re, m_we, if_ready, d_ready}, 0);
    check("rmid_rdata", {if_rdata, d_rdata}, 0);
    check("rmid_err", err, 0);
    check("rmid_m_addr", m_addr, 0);
    rst = 1'b0; m_valid = 1'b1; m_rdata = 16'h9999;
    step();
    m_valid = 1'b0;
    check("rmid_late_valid", {if_ready, m_re, m_we}, 0);
    check("rmid_late_rdata", if_rdata, 0);
    step();
    check("rmid_still_idle", {if_ready, d_ready, m_re, m_we}, 0);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
